// File: rtl/wptr_full_ctrl_pkg.sv
// Shared constants for the write-side pointer / full-flag controller of the async FIFO.
// The read-side controller imports the same package.
package wptr_full_ctrl_pkg;

  localparam int WPTR_WIDTH   = 8;
  localparam int FIFO_DEPTH   = 1 << (WPTR_WIDTH - 1);
  localparam int SYNC_STAGES  = 2;
  localparam int AFULL_THRESH = 4;

endpackage

// File: rtl/wptr_full_ctrl_if.sv
// Write-side FIFO bus: producer request and read-pointer input, plus the
// RAM write port and status flags returned by the controller.
interface wptr_full_ctrl_if
  import wptr_full_ctrl_pkg::*;
#(
  parameter int PTR_WIDTH = WPTR_WIDTH
);

  logic                 winc;
  logic [PTR_WIDTH-1:0] rptr_gray;
  logic                 wen;
  logic [PTR_WIDTH-2:0] waddr;
  logic [PTR_WIDTH-1:0] wptr_gray;
  logic                 wfull;
  logic                 wafull;
  logic                 wovf;

  modport master (
    output winc, rptr_gray,
    input  wen, waddr, wptr_gray, wfull, wafull, wovf
  );

  modport slave (
    input  winc, rptr_gray,
    output wen, waddr, wptr_gray, wfull, wafull, wovf
  );

endinterface

// File: rtl/wptr_full_ctrl_g2b.sv
// Gray-to-binary converter: each binary bit is the XOR of all Gray bits from the MSB down.
// Shared by the write- and read-side pointer controllers.
module wptr_full_ctrl_g2b #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    assign bin[gi] = ^gray[WIDTH-1:gi];
  end

endmodule

// File: rtl/wptr_full_ctrl.sv
// Write-domain pointer and full/almost-full/overflow flag controller for the async FIFO.
// The Gray pointer is registered directly so the read domain never sees a glitch.
module wptr_full_ctrl
  import wptr_full_ctrl_pkg::*;
#(
  parameter int PTR_WIDTH    = wptr_full_ctrl_pkg::WPTR_WIDTH,
  parameter int SYNC_STAGES  = wptr_full_ctrl_pkg::SYNC_STAGES,
  parameter int AFULL_THRESH = wptr_full_ctrl_pkg::AFULL_THRESH
) (
  input  logic                    wclk,
  input  logic                    wrst,
  wptr_full_ctrl_if.slave         bus
);

  localparam int                   DEPTH       = 1 << (PTR_WIDTH - 1);
  localparam logic [PTR_WIDTH-1:0] AFULL_LEVEL = PTR_WIDTH'(DEPTH - AFULL_THRESH);

  logic [PTR_WIDTH-1:0] wbin_q, wbin_d;
  logic [PTR_WIDTH-1:0] wgray_q, wgray_d;
  logic                 wfull_q, wfull_d;
  logic                 wafull_q, wafull_d;
  logic                 wovf_q, wovf_d;
  logic                 accept;
  logic [PTR_WIDTH-1:0] wq_rptr;
  logic [PTR_WIDTH-1:0] rbin_sync;
  logic [PTR_WIDTH-1:0] full_cmp;
  logic [PTR_WIDTH-1:0] fill_d;

  // Plain flop chain: no logic between stages so each bit resolves independently.
  for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
    logic [PTR_WIDTH-1:0] stage_d, stage_q;
    if (gi == 0) begin : g_first
      assign stage_d = bus.rptr_gray;
    end else begin : g_next
      assign stage_d = g_sync[gi-1].stage_q;
    end
    always_ff @(posedge wclk) begin
      if (wrst) stage_q <= '0;
      else      stage_q <= stage_d;
    end
  end

  assign wq_rptr = g_sync[SYNC_STAGES-1].stage_q;

  wptr_full_ctrl_g2b #(
    .WIDTH (PTR_WIDTH)
  ) u_g2b (
    .gray (wq_rptr),
    .bin  (rbin_sync)
  );

  always_comb begin
    accept   = bus.winc & ~wfull_q;
    wbin_d   = wbin_q + {{(PTR_WIDTH-1){1'b0}}, accept};
    wgray_d  = wbin_d ^ (wbin_d >> 1);
    // Full when the writer is exactly one lap ahead: top two Gray bits inverted.
    full_cmp = {~wq_rptr[PTR_WIDTH-1 -: 2], wq_rptr[PTR_WIDTH-3:0]};
    wfull_d  = (wgray_d == full_cmp);
    fill_d   = wbin_d - rbin_sync;
    wafull_d = (fill_d >= AFULL_LEVEL);
    wovf_d   = wovf_q | (bus.winc & wfull_q);
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      wbin_q   <= '0;
      wgray_q  <= '0;
      wfull_q  <= 1'b0;
      wafull_q <= 1'b0;
      wovf_q   <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wgray_q  <= wgray_d;
      wfull_q  <= wfull_d;
      wafull_q <= wafull_d;
      wovf_q   <= wovf_d;
    end
  end

  assign bus.wen       = accept;
  assign bus.waddr     = wbin_q[PTR_WIDTH-2:0];
  assign bus.wptr_gray = wgray_q;
  assign bus.wfull     = wfull_q;
  assign bus.wafull    = wafull_q;
  assign bus.wovf      = wovf_q;

endmodule
